// File: rtl/dll_track_ctrl_pkg.sv
// Shared definitions for the DLL coarse/fine lock path.
// State and direction encodings plus the common code width.
package dll_track_ctrl_pkg;

    localparam int DLL_CODE_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

endpackage

// File: rtl/dll_track_ctrl_vote.sv
// Majority-vote filter over FILT_LEN phase-detector samples.
// Decision is combinational on the edge that takes the last sample.
module dll_vote_filter
    import dll_track_ctrl_pkg::*;
#(
    parameter int FILT_LEN = 8,
    parameter int TH       = 2
) (
    input  logic clk_ext,
    input  logic rst_n,
    input  logic clr,
    input  logic vld,
    input  logic comp,
    output logic dec_vld,
    output dir_t dec_dir
);

    localparam int WW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int UW = $clog2(FILT_LEN + 1);

    localparam logic [WW-1:0] WIN_LAST = WW'(FILT_LEN - 1);
    localparam logic [UW-1:0] UP_TH    = UW'(FILT_LEN - TH);
    localparam logic [UW-1:0] DN_TH    = UW'(TH);

    logic [WW-1:0] win_cnt;
    logic [UW-1:0] up_cnt;
    logic [UW-1:0] up_tot;
    logic          last;

    assign up_tot  = up_cnt + UW'(comp);
    assign last    = (win_cnt == WIN_LAST);
    assign dec_vld = vld & last;

    always_comb begin
        dec_dir = DIR_NONE;
        if (up_tot >= UP_TH) begin
            dec_dir = DIR_UP;
        end else if (up_tot <= DN_TH) begin
            dec_dir = DIR_DN;
        end
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            up_cnt  <= '0;
        end else if (clr) begin
            win_cnt <= '0;
            up_cnt  <= '0;
        end else if (vld) begin
            if (last) begin
                win_cnt <= '0;
                up_cnt  <= '0;
            end else begin
                win_cnt <= win_cnt + WW'(1);
                up_cnt  <= up_tot;
            end
        end
    end

endmodule

// File: rtl/dll_track_ctrl.sv
// Bang-bang fine tracking of the DLL delay code after SAR coarse lock.
// Declares lock on dithering, requests a SAR re-search on runaway.
module dll_track_ctrl
    import dll_track_ctrl_pkg::*;
#(
    parameter int CODE_W     = DLL_CODE_W,
    parameter int FILT_LEN   = 8,
    parameter int TH         = 2,
    parameter int LOCK_CNT   = 4,
    parameter int RELOCK_RUN = 6
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sar_done,
    input  logic [CODE_W-1:0] sar_code,
    input  logic              comp,
    input  logic              comp_vld,
    output logic [CODE_W-1:0] code,
    output logic              code_upd,
    output logic              lock,
    output logic              relock_req,
    output logic [1:0]        state
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(RELOCK_RUN + 1);

    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);
    localparam logic [RW-1:0] RUN_MAX  = RW'(RELOCK_RUN);

    state_t            st_q, st_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              upd_q, upd_d;
    logic              lock_q, lock_d;
    logic              rr_q, rr_d;
    logic [LW-1:0]     lcnt_q, lcnt_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    dir_t              ldir_q, ldir_d;

    logic              active;
    logic              f_clr;
    logic              f_vld;
    logic              dec_vld;
    dir_t              dec_dir;

    logic [LW-1:0]     lcnt_inc, lcnt_x;
    logic [RW-1:0]     rcnt_inc, rcnt_x;
    dir_t              ldir_x;
    logic [CODE_W-1:0] up_code, dn_code, step_code;

    assign active = (st_q != ST_IDLE);
    assign f_vld  = comp_vld & en & active & ~sar_done;
    assign f_clr  = ~en | sar_done | ~active;

    dll_vote_filter #(
        .FILT_LEN (FILT_LEN),
        .TH       (TH)
    ) u_vote (
        .clk_ext (clk_ext),
        .rst_n   (rst_n),
        .clr     (f_clr),
        .vld     (f_vld),
        .comp    (comp),
        .dec_vld (dec_vld),
        .dec_dir (dec_dir)
    );

    // Saturated steps still count toward the run length below.
    assign up_code = (code_q == '1) ? code_q : code_q + CODE_W'(1);
    assign dn_code = (code_q == '0) ? code_q : code_q - CODE_W'(1);

    always_comb begin
        step_code = code_q;
        if (dec_dir == DIR_UP) begin
            step_code = up_code;
        end else if (dec_dir == DIR_DN) begin
            step_code = dn_code;
        end
    end

    assign lcnt_inc = (lcnt_q == LOCK_MAX) ? lcnt_q : lcnt_q + LW'(1);
    assign rcnt_inc = (rcnt_q == RUN_MAX) ? rcnt_q : rcnt_q + RW'(1);

    always_comb begin
        lcnt_x = lcnt_inc;
        rcnt_x = '0;
        ldir_x = ldir_q;
        if (dec_dir != DIR_NONE) begin
            if (dec_dir == ldir_q) begin
                lcnt_x = '0;
                rcnt_x = rcnt_inc;
            end else begin
                rcnt_x = RW'(1);
                ldir_x = dec_dir;
            end
        end
    end

    always_comb begin
        st_d   = st_q;
        code_d = code_q;
        upd_d  = 1'b0;
        lock_d = lock_q;
        rr_d   = 1'b0;
        lcnt_d = lcnt_q;
        rcnt_d = rcnt_q;
        ldir_d = ldir_q;
        unique case (1'b1)
            !en: begin
                st_d   = ST_IDLE;
                lock_d = 1'b0;
                lcnt_d = '0;
                rcnt_d = '0;
                ldir_d = DIR_NONE;
            end
            en && sar_done: begin
                st_d   = ST_TRACK;
                code_d = sar_code;
                upd_d  = 1'b1;
                lock_d = 1'b0;
                lcnt_d = '0;
                rcnt_d = '0;
                ldir_d = DIR_NONE;
            end
            dec_vld: begin
                if (rcnt_x >= RUN_MAX) begin
                    st_d   = ST_IDLE;
                    rr_d   = 1'b1;
                    lock_d = 1'b0;
                    lcnt_d = '0;
                    rcnt_d = '0;
                    ldir_d = DIR_NONE;
                end else begin
                    code_d = step_code;
                    upd_d  = (step_code != code_q);
                    lcnt_d = lcnt_x;
                    rcnt_d = rcnt_x;
                    ldir_d = ldir_x;
                    if (st_q == ST_TRACK && lcnt_x >= LOCK_MAX) begin
                        st_d   = ST_LOCKED;
                        lock_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            code_q <= '0;
            upd_q  <= 1'b0;
            lock_q <= 1'b0;
            rr_q   <= 1'b0;
            lcnt_q <= '0;
            rcnt_q <= '0;
            ldir_q <= DIR_NONE;
        end else begin
            st_q   <= st_d;
            code_q <= code_d;
            upd_q  <= upd_d;
            lock_q <= lock_d;
            rr_q   <= rr_d;
            lcnt_q <= lcnt_d;
            rcnt_q <= rcnt_d;
            ldir_q <= ldir_d;
        end
    end

    assign code       = code_q;
    assign code_upd   = upd_q;
    assign lock       = lock_q;
    assign relock_req = rr_q;
    assign state      = st_q;

endmodule

// File: tb/tb_dll_track_ctrl.sv
// Self-checking bench for dll_track_ctrl: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_dll_track_ctrl;

    localparam int CW    = 10;
    localparam int FL    = 8;
    localparam int TH    = 2;
    localparam int LOCKN = 4;
    localparam int RUNN  = 6;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk_ext = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sar_done;
    logic [CW-1:0] sar_code;
    logic          comp;
    logic          comp_vld;
    logic [CW-1:0] code;
    logic          code_upd;
    logic          lock;
    logic          relock_req;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_code, m_upd, m_lock, m_rr, m_state;
    int m_win, m_ones, m_lockc, m_run, m_last;

    dll_track_ctrl dut (
        .clk_ext    (clk_ext),
        .rst_n      (rst_n),
        .en         (en),
        .sar_done   (sar_done),
        .sar_code   (sar_code),
        .comp       (comp),
        .comp_vld   (comp_vld),
        .code       (code),
        .code_upd   (code_upd),
        .lock       (lock),
        .relock_req (relock_req),
        .state      (state)
    );

    always #5 clk_ext = ~clk_ext;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_win = 0; m_ones = 0; m_lockc = 0; m_run = 0; m_last = 0;
    endtask

    task automatic m_reset();
        m_code = 0; m_upd = 0; m_lock = 0; m_rr = 0; m_state = 0;
        m_clear();
    endtask

    // one clock edge of the behavioural model; direction: +1 up, -1 down, 0 hold
    task automatic m_step(input bit e, input bit sd, input int sc, input bit c, input bit cv);
        int d;
        int nc;
        m_upd = 0;
        m_rr  = 0;
        if (!e) begin
            m_state = 0; m_lock = 0; m_clear();
        end else if (sd) begin
            m_code = sc; m_upd = 1; m_state = 1; m_lock = 0; m_clear();
        end else if (m_state != 0 && cv) begin
            m_win++;
            m_ones += int'(c);
            if (m_win == FL) begin
                d = (m_ones >= FL - TH) ? 1 : (m_ones <= TH) ? -1 : 0;
                m_win = 0; m_ones = 0;
                if (d == 0) begin
                    m_lockc++; m_run = 0;
                end else if (d != m_last) begin
                    m_lockc++; m_run = 1; m_last = d;
                end else begin
                    m_run++; m_lockc = 0;
                end
                if (m_run >= RUNN) begin
                    m_rr = 1; m_lock = 0; m_state = 0; m_clear();
                end else begin
                    nc = m_code + d;
                    if (nc < 0) nc = 0;
                    if (nc > CMAX) nc = CMAX;
                    m_upd  = (nc != m_code) ? 1 : 0;
                    m_code = nc;
                    if (m_state == 1 && m_lockc >= LOCKN) begin
                        m_state = 2; m_lock = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk_all();
        chk("code", int'(code), m_code);
        chk("code_upd", int'(code_upd), m_upd);
        chk("lock", int'(lock), m_lock);
        chk("relock_req", int'(relock_req), m_rr);
        chk("state", int'(state), m_state);
    endtask

    task automatic tick(input bit e, input bit sd, input int sc, input bit c, input bit cv);
        en       = e;
        sar_done = sd;
        sar_code = CW'(sc);
        comp     = c;
        comp_vld = cv;
        @(posedge clk_ext);
        m_step(e, sd, sc, c, cv);
        #1;
        chk_all();
        sar_done = 1'b0;
        comp_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_all();
        @(posedge clk_ext);
        #1;
        rst_n = 1'b1;
    endtask

    // one vote window with `ones` set samples in random order and random gaps
    task automatic window(input int ones);
        bit s[FL];
        bit t;
        int j;
        for (int i = 0; i < FL; i++) s[i] = (i < ones);
        for (int i = FL - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int i = 0; i < FL; i++) begin
            if ($urandom_range(2, 0) == 0) tick(1, 0, 0, 0, 0);
            tick(1, 0, 0, s[i], 1);
        end
    endtask

    initial begin
        int p;
        int sc;
        rst_n = 1'b0; en = 1'b0; sar_done = 1'b0;
        sar_code = '0; comp = 1'b0; comp_vld = 1'b0;
        m_reset();
        @(posedge clk_ext);
        do_reset();
        chk("rst_state", int'(state), 0);

        // load, single up window, then a hold window
        tick(1, 1, 512, 0, 0);
        chk("load_code", int'(code), 512);
        chk("load_upd", int'(code_upd), 1);
        window(8);
        chk("up_code", int'(code), 513);
        window(5);
        chk("hold_code", int'(code), 513);

        // dithering reaches lock
        tick(1, 1, 512, 0, 0);
        window(8); window(0); window(8); window(0);
        chk("lock_flag", int'(lock), 1);
        chk("lock_state", int'(state), 2);
        chk("lock_code", int'(code), 512);
        tick(0, 0, 0, 0, 0);
        chk("en_off_state", int'(state), 0);
        chk("en_off_code", int'(code), 512);

        // saturation and runaway
        tick(1, 1, 1020, 0, 0);
        for (int w = 0; w < 6; w++) window(8);
        chk("run_rr", int'(relock_req), 1);
        chk("run_state", int'(state), 0);
        chk("run_code", int'(code), 1023);
        tick(1, 0, 0, 0, 0);
        chk("rr_pulse", int'(relock_req), 0);

        // async reset mid-window
        tick(1, 1, 200, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1, 1);
        do_reset();
        chk("rst_code", int'(code), 0);

        // reload beats both a pending step and a pending relock
        tick(1, 1, 100, 0, 0);
        for (int w = 0; w < 5; w++) window(8);
        for (int i = 0; i < FL - 1; i++) tick(1, 0, 0, 1, 1);
        tick(1, 1, 300, 1, 1);
        chk("coin_code", int'(code), 300);
        chk("coin_state", int'(state), 1);
        chk("coin_rr", int'(relock_req), 0);

        // randomized traffic
        p = 2;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc % 120 == 0) p = $urandom_range(3, 0);
            if (cyc % 1500 == 1499) do_reset();
            case ($urandom_range(4, 0))
                0: sc = 0;
                1: sc = CMAX;
                2: sc = $urandom_range(3, 1);
                3: sc = CMAX - $urandom_range(3, 1);
                default: sc = $urandom_range(CMAX, 0);
            endcase
            tick($urandom_range(299, 0) != 0,
                 $urandom_range(149, 0) == 0,
                 sc,
                 (p == 0) ? 1'b0 : (p == 1) ? 1'b1 :
                 (p == 2) ? 1'($urandom_range(1, 0)) :
                 ($urandom_range(7, 0) != 0),
                 $urandom_range(3, 0) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dll_track_ctrl.md
Name: dll_track_ctrl

Overview:
- Fine-tracking controller downstream of the PTC coarse-lock stage.
- Takes over the 10-bit delay code once the SAR search completes.
- Performs bang-bang tracking on PD comparison results, filtered by majority vote, and drives the delay-line control code.
- Reports lock status; requests a SAR re-search when tracking runs away in one direction.

Parameters:
- CODE_W, 10, width of delay control code (matches SAR Q).
- FILT_LEN, 8, PD samples per vote window (power of 2, 2..64).
- TH, 2, vote margin; up-count >= FILT_LEN-TH means step up, up-count <= TH means step down, otherwise hold.
- LOCK_CNT, 4, consecutive non-monotonic decisions needed to declare lock.
- RELOCK_RUN, 6, consecutive same-direction steps that trigger a relock request.

Ports:
- clk_ext  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  tracking enable.
- sar_done  in  1  single-cycle pulse; SAR search complete, sar_code valid.
- sar_code  in  CODE_W  final SAR code (PTC Q).
- comp  in  1  PD result; 1 = increase delay, 0 = decrease.
- comp_vld  in  1  comp valid strobe, at most one per cycle.
- code  out  CODE_W  delay control code to DCDL / decoder.
- code_upd  out  1  one-cycle pulse when code changes.
- lock  out  1  lock indicator.
- relock_req  out  1  one-cycle pulse requesting new SAR search.
- state  out  2  FSM state: IDLE=0, TRACK=1, LOCKED=2.

Behaviour:
- Reset (async, rst_n=0): code=0, code_upd=0, lock=0, relock_req=0, state=IDLE. win_cnt, up_cnt, lock_cnt, run_cnt and last_dir are cleared.
- All outputs are registered. Counters clear when leaving IDLE.
- IDLE:
  - comp_vld is ignored.
  - On sar_done=1 with en=1: on that edge, code<=sar_code and code_upd=1; go to TRACK and clear counters.
  - sar_done with en=0 is ignored.
- Vote window (TRACK and LOCKED): each comp_vld increments win_cnt and adds comp to up_cnt.
  - On the edge that samples the FILT_LEN-th comp_vld, the decision uses up_cnt including that sample, and the window counters clear on the same edge.
  - The code step lands on that same edge, so code_upd pulses the following cycle as a registered output.
- Decision rules:
  - UP: code+1, saturating at 2^CODE_W-1.
  - DOWN: code-1, saturating at 0.
  - HOLD: code unchanged.
  - A saturated step still counts as its direction for run_cnt, but code_upd stays 0 because code does not change.
- Lock tracking:
  - If the decision is HOLD, or its direction is opposite to last_dir: lock_cnt++ and run_cnt=1 (run_cnt=0 for HOLD).
  - If the direction equals last_dir: run_cnt++ and lock_cnt=0.
  - last_dir updates only on UP/DOWN.
- TRACK to LOCKED: when lock_cnt reaches LOCK_CNT, lock=1 on the same edge.
- Runaway: in TRACK or LOCKED, when run_cnt reaches RELOCK_RUN:
  - relock_req pulses for 1 cycle, lock=0, state goes to IDLE.
  - code holds its last value.
- LOCKED: the same filter continues running. lock stays 1 until a runaway or en=0.
- en=0 in any state: next edge goes to IDLE, lock=0, counters clear, code holds, no relock_req.
- sar_done in TRACK or LOCKED (with en=1): reload code from sar_code, clear counters, state=TRACK, lock=0. This has priority over a vote decision on the same edge.
- A comp_vld on the same edge as sar_done is discarded.
- relock_req and sar_done on the same edge: sar_done wins, and relock_req is suppressed.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE, ST_TRACK, ST_LOCKED);
  - direction encoding (DIR_NONE/UP/DN);
  - default CODE_W=10, used by both PTC and this block.
- One natural sub-module: dll_vote_filter. It contains win_cnt, up_cnt and the threshold compare, and outputs a decision valid pulse and direction.
- FSM, code register and lock/run counters stay in the top.

Test Plan:
- Reset then sar_done with sar_code=10'd512, en=1 -> code=512, code_upd pulse, state=TRACK.
- In TRACK, 8 comp_vld with comp=1 -> code=513 on the 8th sample edge. Pattern 5 ones / 3 zeros -> HOLD, code stays 513.
- Alternating windows UP, DOWN, UP, DOWN from code=512 -> after the 4th decision lock=1, state=LOCKED, code=512.
- sar_code=10'd1020, then 6 consecutive all-ones windows -> code saturates at 1023 with no code_upd once saturated. The 6th window produces a relock_req pulse, state=IDLE, lock=0, code=1023.
- From LOCKED: drop en -> state=IDLE, lock=0, code held. Async rst_n low mid-window -> all outputs return to reset values immediately.
- sar_done coincident with the 8th comp_vld of an all-ones window -> code=sar_code (no +1), state=TRACK, relock_req=0.
